// File: rtl/vgm_pkg.sv
// Shared constants and FSM state type for the VGM-to-YM2149 command player.
package vgm_pkg;

  // VGM opcodes understood by the player
  localparam logic [7:0] OP_AY_WRITE   = 8'hA0;
  localparam logic [7:0] OP_WAIT_N     = 8'h61;
  localparam logic [7:0] OP_WAIT_735   = 8'h62;
  localparam logic [7:0] OP_WAIT_882   = 8'h63;
  localparam logic [3:0] OP_WAIT_SHORT = 4'h7;   // upper nibble of 0x70-0x7F
  localparam logic [7:0] OP_END        = 8'h66;

  // Canned frame waits in 44.1 kHz samples (60 Hz / 50 Hz frames)
  localparam logic [15:0] WAIT_NTSC = 16'd735;
  localparam logic [15:0] WAIT_PAL  = 16'd882;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_ARG0,
    ST_ARG1,
    ST_WRITE,
    ST_GAP,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the player is working on a command and cannot take bytes
  function automatic logic is_busy_state(state_t s);
    return s inside {ST_WRITE, ST_GAP, ST_WAIT};
  endfunction

endpackage

// File: rtl/vgm_wait_timer.sv
// Sample-accurate wait timer: a SAMPLE_DIV clock divider feeding a 16-bit
// sample down-counter. expire is high on the last clock of an N-sample wait,
// so a wait loaded with N and counted continuously lasts N*SAMPLE_DIV clocks.
module vgm_wait_timer #(
  parameter int SAMPLE_DIV = 567
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        count,
  output logic        expire
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [15:0]      samples_q;

  // Divider and sample counter; load restarts the divider from zero
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      div_q     <= '0;
      samples_q <= '0;
    end else if (load) begin
      div_q     <= '0;
      samples_q <= load_val;
    end else if (count) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (samples_q != 16'd0) samples_q <= samples_q - 16'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign expire = count && (samples_q <= 16'd1) && (div_q == DIV_LAST);

endmodule

// File: rtl/vgm_psg_player.sv
// VGM command stream decoder driving the YM2149 register-write port.
// Accepts one byte per transfer, emits shaped write strobes and timed waits.
module vgm_psg_player
  import vgm_pkg::*;
#(
  parameter int SAMPLE_DIV = 567,
  parameter int WR_HOLD    = 2,
  parameter int WR_GAP     = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [3:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
);

  localparam int STROBE_MAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int SC_W       = $clog2(STROBE_MAX + 1);
  localparam logic [SC_W-1:0] HOLD_LAST = SC_W'(WR_HOLD - 1);
  localparam logic [SC_W-1:0] GAP_LAST  = SC_W'(WR_GAP - 1);

  state_t          state_q, state_d;
  logic [7:0]      op_q;
  logic [7:0]      arg0_q;
  logic [SC_W-1:0] strobe_cnt_q;
  logic            xfer;
  logic            wr_commit;
  logic            timer_load;
  logic [15:0]     timer_val;
  logic            timer_expire;

  assign out_ready = state_q inside {ST_OPCODE, ST_ARG0, ST_ARG1};
  assign out_done  = (state_q == ST_DONE);
  assign out_err   = (state_q == ST_ERR);
  assign xfer      = in_valid & out_ready;

  vgm_wait_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_wait_timer (
    .clk     (in_clk),
    .rst     (in_rst),
    .load    (timer_load),
    .load_val(timer_val),
    .count   (state_q == ST_WAIT),
    .expire  (timer_expire)
  );

  // Next-state decode, timer load and register-write commit
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = 16'd0;
    wr_commit  = 1'b0;
    unique case (state_q)
      ST_OPCODE: begin
        if (xfer) begin
          if (in_data == OP_AY_WRITE || in_data == OP_WAIT_N) begin
            state_d = ST_ARG0;
          end else if (in_data == OP_WAIT_735) begin
            timer_load = 1'b1;
            timer_val  = WAIT_NTSC;
            state_d    = ST_WAIT;
          end else if (in_data == OP_WAIT_882) begin
            timer_load = 1'b1;
            timer_val  = WAIT_PAL;
            state_d    = ST_WAIT;
          end else if (in_data[7:4] == OP_WAIT_SHORT) begin
            timer_load = 1'b1;
            timer_val  = {12'd0, in_data[3:0]} + 16'd1;
            state_d    = ST_WAIT;
          end else if (in_data == OP_END) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ARG0: begin
        if (xfer) state_d = ST_ARG1;
      end
      ST_ARG1: begin
        if (xfer) begin
          if (op_q == OP_AY_WRITE) begin
            // Only the first chip's 16 registers are writable; others are dropped
            if (arg0_q[7:4] == 4'd0) begin
              wr_commit = 1'b1;
              state_d   = ST_WRITE;
            end else begin
              state_d = ST_OPCODE;
            end
          end else if ({in_data, arg0_q} == 16'd0) begin
            state_d = ST_OPCODE;
          end else begin
            timer_load = 1'b1;
            timer_val  = {in_data, arg0_q};
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WRITE: begin
        if (strobe_cnt_q == HOLD_LAST) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (strobe_cnt_q == GAP_LAST) state_d = ST_OPCODE;
      end
      ST_WAIT: begin
        if (timer_expire) state_d = ST_OPCODE;
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_OPCODE;
    endcase
  end

  // State, argument capture, strobe timing and registered port outputs
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= ST_OPCODE;
      op_q         <= 8'd0;
      arg0_q       <= 8'd0;
      strobe_cnt_q <= '0;
      out_reg      <= 4'd0;
      out_val      <= 8'd0;
      out_wr       <= 1'b0;
      out_busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer && state_q == ST_OPCODE) op_q   <= in_data;
      if (xfer && state_q == ST_ARG0)   arg0_q <= in_data;
      if (wr_commit) begin
        out_reg <= arg0_q[3:0];
        out_val <= in_data;
      end
      if (state_d != state_q) begin
        strobe_cnt_q <= '0;
      end else if (state_q inside {ST_WRITE, ST_GAP}) begin
        strobe_cnt_q <= strobe_cnt_q + SC_W'(1);
      end
      // Strobe and busy are registered from the next state so they are glitch-free
      out_wr   <= (state_d == ST_WRITE);
      out_busy <= is_busy_state(state_d);
    end
  end

endmodule

// File: tb/tb_vgm_psg_player.sv
// Directed bench for vgm_psg_player: writes, waits, discards, terminal states,
// reset aborts and a gapped multi-command stream.
module tb_vgm_psg_player;

  localparam int DIV = 20;
  localparam int HOLD = 2;
  localparam int GAP = 2;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       out_ready;
  logic [3:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_busy;
  logic       out_done;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  vgm_psg_player #(
    .SAMPLE_DIV(DIV),
    .WR_HOLD   (HOLD),
    .WR_GAP    (GAP)
  ) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_err  (out_err)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Present one byte after 'gap' idle cycles; returns just after it transfers
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!out_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check("ready_timeout", 32'(out_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
  endtask

  // Count consecutive sampled cycles with out_wr (sel=0) or out_busy (sel=1) high
  task automatic measure(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? out_wr : out_busy) && n < 100000) begin
      n++;
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(out_ready), 32'd1);
    check({tag, "_wr"},    32'(out_wr),    32'd0);
    check({tag, "_busy"},  32'(out_busy),  32'd0);
    check({tag, "_done"},  32'(out_done),  32'd0);
    check({tag, "_err"},   32'(out_err),   32'd0);
    check({tag, "_reg"},   32'(out_reg),   32'd0);
    check({tag, "_val"},   32'(out_val),   32'd0);
  endtask

  typedef struct {
    logic [7:0] op;
    int         samples;
  } wait_vec_t;

  initial begin
    int n;
    wait_vec_t waits [4];
    logic [3:0] r;
    logic [7:0] v;

    // Reset state
    in_rst = 1'b1;
    repeat (3) tick();
    in_rst = 1'b0;
    check_idle("reset");

    // AY write: reg 7 = 0x38, strobe 2 high, 2 low, ready returns
    send3(8'hA0, 8'h07, 8'h38, 0);
    check("w1_wr_first", 32'(out_wr), 32'd1);
    check("w1_reg", 32'(out_reg), 32'd7);
    check("w1_val", 32'(out_val), 32'h38);
    check("w1_ready_low", 32'(out_ready), 32'd0);
    measure(0, n);
    check("w1_hold_cycles", 32'(n), 32'(HOLD));
    check("w1_gap_busy", 32'(out_busy), 32'd1);
    measure(1, n);
    check("w1_gap_cycles", 32'(n), 32'(GAP));
    check("w1_ready_back", 32'(out_ready), 32'd1);
    check("w1_reg_stable", 32'(out_reg), 32'd7);
    check("w1_val_stable", 32'(out_val), 32'h38);

    // 0x61 wait of 10 samples
    send3(8'h61, 8'h0A, 8'h00, 0);
    measure(1, n);
    check("wait10_cycles", 32'(n), 32'(10 * DIV));
    check("wait10_ready_after", 32'(out_ready), 32'd1);

    // Canned and short waits
    waits[0] = '{8'h62, 735};
    waits[1] = '{8'h63, 882};
    waits[2] = '{8'h7F, 16};
    waits[3] = '{8'h70, 1};
    foreach (waits[i]) begin
      send_byte(waits[i].op, 0);
      measure(1, n);
      check($sformatf("wait_op%0h_cycles", waits[i].op), 32'(n), 32'(waits[i].samples * DIV));
      check($sformatf("wait_op%0h_ready", waits[i].op), 32'(out_ready), 32'd1);
    end

    // Zero-length wait skips WAIT entirely
    send3(8'h61, 8'h00, 8'h00, 0);
    check("wait0_busy", 32'(out_busy), 32'd0);
    check("wait0_ready", 32'(out_ready), 32'd1);

    // Out-of-range register discarded, then a real write
    send3(8'hA0, 8'h85, 8'h12, 0);
    check("discard_wr", 32'(out_wr), 32'd0);
    check("discard_busy", 32'(out_busy), 32'd0);
    check("discard_ready", 32'(out_ready), 32'd1);
    check("discard_reg_kept", 32'(out_reg), 32'd7);
    send3(8'hA0, 8'h01, 8'hFF, 0);
    check("w2_reg", 32'(out_reg), 32'd1);
    check("w2_val", 32'(out_val), 32'hFF);
    measure(0, n);
    check("w2_hold_cycles", 32'(n), 32'(HOLD));

    // End of stream is terminal
    send_byte(8'h66, 0);
    check("done_flag", 32'(out_done), 32'd1);
    check("done_ready", 32'(out_ready), 32'd0);
    check("done_no_err", 32'(out_err), 32'd0);
    check("done_busy", 32'(out_busy), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) tick();
    check("done_sticky", 32'(out_done), 32'd1);
    check("done_ready_stays", 32'(out_ready), 32'd0);
    check("done_no_err_later", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check_idle("rst_after_done");

    // Unknown opcode
    send_byte(8'h55, 0);
    check("err_flag", 32'(out_err), 32'd1);
    check("err_no_done", 32'(out_done), 32'd0);
    check("err_ready", 32'(out_ready), 32'd0);
    repeat (3) tick();
    check("err_sticky", 32'(out_err), 32'd1);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check_idle("rst_after_err");

    // Reset mid-wait
    send3(8'h61, 8'h05, 8'h00, 0);
    repeat (30) tick();
    check("midwait_busy", 32'(out_busy), 32'd1);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check_idle("rst_midwait");

    // Reset mid-strobe: out_wr falls on the reset edge
    send3(8'hA0, 8'h03, 8'h44, 0);
    check("midwr_wr", 32'(out_wr), 32'd1);
    in_rst = 1'b1;
    tick();
    check("midwr_wr_fall", 32'(out_wr), 32'd0);
    in_rst = 1'b0;
    check_idle("rst_midwr");

    // Gapped stream of writes, discards and short waits
    for (int i = 0; i < 6; i++) begin
      r = 4'((i * 5 + 2) % 16);
      v = 8'((i * 37 + 11) % 256);
      send3(8'hA0, {4'd0, r}, v, int'($urandom_range(0, 3)));
      check($sformatf("s%0d_wr", i), 32'(out_wr), 32'd1);
      check($sformatf("s%0d_reg", i), 32'(out_reg), 32'(r));
      check($sformatf("s%0d_val", i), 32'(out_val), 32'(v));
      measure(0, n);
      check($sformatf("s%0d_hold", i), 32'(n), 32'(HOLD));
      if (i % 2 == 0) begin
        send_byte(8'h71, int'($urandom_range(0, 3)));
        measure(1, n);
        check($sformatf("s%0d_wait2", i), 32'(n), 32'(2 * DIV));
      end else begin
        send3(8'hA0, 8'hF3, 8'h99, int'($urandom_range(0, 3)));
        check($sformatf("s%0d_discard_wr", i), 32'(out_wr), 32'd0);
        check($sformatf("s%0d_discard_reg", i), 32'(out_reg), 32'(r));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
